// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single external memory port.
// Grants one requester, waits MEM_LAT cycles, captures the word and pulses that requester's ack.
module mem_port_arbiter #(
  parameter int AW      = 6,
  parameter int DW      = 6,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          ack0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_valid,
  input  logic [DW-1:0] mem_data,
  output logic          gnt_id,
  output logic          busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t       state;
  logic         rr_ptr;
  logic [2:0]   lat_cnt;

  logic         elig0, elig1, any_elig, gnt_sel;
  logic [AW-1:0] addr_sel;

  // A requester whose ack is currently high is masked so a held req is not re-granted.
  always_comb begin
    elig0    = req0 & ~ack0;
    elig1    = req1 & ~ack1;
    any_elig = elig0 | elig1;
    gnt_sel  = 1'b0;
    if (elig0 && elig1) gnt_sel = rr_ptr;
    else                gnt_sel = elig1;
    addr_sel = gnt_sel ? addr1 : addr0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_valid <= 1'b0;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      gnt_id    <= 1'b0;
      busy      <= 1'b0;
      rr_ptr    <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            mem_addr  <= addr_sel;
            mem_valid <= 1'b1;
            gnt_id    <= gnt_sel;
            busy      <= 1'b1;
            lat_cnt   <= LAT_INIT;
            rr_ptr    <= ~gnt_sel;
            state     <= WAIT;
          end else begin
            mem_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (lat_cnt == 3'd1) begin
            rdata     <= mem_data;
            if (gnt_id) ack1 <= 1'b1;
            else        ack0 <= 1'b1;
            mem_valid <= 1'b0;
            busy      <= 1'b0;
            lat_cnt   <= '0;
            state     <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a MEM_LAT=1 instance with a scoreboard-checked
// memory model and a MEM_LAT=3 instance with hand-driven memory data.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  // MEM_LAT=1 instance
  logic       req0 = 0, req1 = 0;
  logic [5:0] addr0 = 0, addr1 = 0;
  logic       ack0, ack1, mem_valid, gnt_id, busy;
  logic [5:0] rdata, mem_addr, mem_data;

  // MEM_LAT=3 instance
  logic       b_req0 = 0, b_req1 = 0;
  logic [5:0] b_addr0 = 0, b_addr1 = 0;
  logic       b_ack0, b_ack1, b_mem_valid, b_gnt_id, b_busy;
  logic [5:0] b_rdata, b_mem_addr;
  logic [5:0] b_mem_data = 6'h3A;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [5:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic logic [5:0] memf(input logic [5:0] a);
    return (a == 6'h05) ? 6'h2A : (a ^ 6'h15);
  endfunction

  assign mem_data = memf(mem_addr);

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(6), .DW(6), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .gnt_id(gnt_id), .busy(busy)
  );

  mem_port_arbiter #(.AW(6), .DW(6), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .addr0(b_addr0), .ack0(b_ack0),
    .req1(b_req1), .addr1(b_addr1), .ack1(b_ack1),
    .rdata(b_rdata), .mem_addr(b_mem_addr), .mem_valid(b_mem_valid), .mem_data(b_mem_data),
    .gnt_id(b_gnt_id), .busy(b_busy)
  );

  // Scoreboard monitor for the MEM_LAT=1 instance
  logic prev_ack0 = 0, prev_ack1 = 0;
  always @(negedge clk) begin
    if (ack0 && ack1) begin
      checks++; errors++;
      $display("FAIL both_acks: ack0=%0b ack1=%0b, required not both high", ack0, ack1);
    end
    if ((ack0 && prev_ack0) || (ack1 && prev_ack1)) begin
      checks++; errors++;
      $display("FAIL ack_width: ack held two cycles, required one-cycle pulse");
    end
    if (ack0 || ack1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: ack0=%0b ack1=%0b rdata=%h with no pending transaction", ack0, ack1, rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ack1 !== e.id || rdata !== e.data) begin
          errors++;
          $display("FAIL sb_txn: got id=%0b rdata=%h, required id=%0b rdata=%h", ack1, rdata, e.id, e.data);
        end else
          $display("txn ok: id=%0b rdata=%h", ack1, rdata);
      end
    end
    prev_ack0 <= ack0;
    prev_ack1 <= ack1;
  end

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ack0, ack1, mem_valid, gnt_id, busy, rdata, mem_addr} !== 17'd0) begin
      errors++;
      $display("FAIL reset_a: outputs=%h, required 0", {ack0, ack1, mem_valid, gnt_id, busy, rdata, mem_addr});
    end
    checks++;
    if ({b_ack0, b_ack1, b_mem_valid, b_gnt_id, b_busy, b_rdata, b_mem_addr} !== 17'd0) begin
      errors++;
      $display("FAIL reset_b: outputs=%h, required 0", {b_ack0, b_ack1, b_mem_valid, b_gnt_id, b_busy, b_rdata, b_mem_addr});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0 = 1; addr0 = 6'h05;
    sb.push_back('{1'b0, 6'h2A});
    @(negedge clk);
    checks++;
    if ({mem_valid, mem_addr, gnt_id, busy, ack0} !== {1'b1, 6'h05, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_grant: valid=%0b addr=%h gnt=%0b busy=%0b ack0=%0b, required 1 05 0 1 0",
               mem_valid, mem_addr, gnt_id, busy, ack0);
    end
    @(negedge clk);
    req0 = 0;
    checks++;
    if ({ack0, mem_valid, busy, rdata} !== {1'b1, 1'b0, 1'b0, 6'h2A}) begin
      errors++;
      $display("FAIL single_ack: ack0=%0b valid=%0b busy=%0b rdata=%h, required 1 0 0 2a",
               ack0, mem_valid, busy, rdata);
    end
    @(negedge clk);
    checks++;
    if ({ack0, mem_valid, rdata} !== {1'b0, 1'b0, 6'h2A}) begin
      errors++;
      $display("FAIL single_after: ack0=%0b valid=%0b rdata=%h, required 0 0 2a", ack0, mem_valid, rdata);
    end
  endtask

  task automatic test_both();
    int n = 0;
    logic [3:0] seq = 4'b0;
    pulse_reset();
    req0 = 1; addr0 = 6'h10;
    req1 = 1; addr1 = 6'h21;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, memf(6'h10)});
      sb.push_back('{1'b1, memf(6'h21)});
    end
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        seq[n] = ack1;
        n++;
        if (n == 4) begin req0 = 0; req1 = 0; end
      end
    end
    checks++;
    if (n != 4 || seq !== 4'b1010) begin
      errors++;
      $display("FAIL both_alternate: acks=%0d order=%b, required 4 acks order 1010 (lsb first)", n, seq);
    end
  endtask

  task automatic test_held();
    int n = 0;
    int last_c = -10;
    req0 = 1; addr0 = 6'h07;
    for (int i = 0; i < 5; i++) sb.push_back('{1'b0, memf(6'h07)});
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge clk);
      if (ack0) begin
        if (n > 0) begin
          checks++;
          if (c - last_c < 2) begin
            errors++;
            $display("FAIL held_gap: gap=%0d cycles, required >=2", c - last_c);
          end
        end
        last_c = c;
        n++;
        if (n == 5) req0 = 0;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL held_count: acks=%0d, required 5", n);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_valid, busy, ack0} !== 3'b000) begin
      errors++;
      $display("FAIL held_idle: valid=%0b busy=%0b ack0=%0b, required 0 0 0", mem_valid, busy, ack0);
    end
  endtask

  task automatic test_latency3();
    @(negedge clk);
    b_req1 = 1; b_addr1 = 6'h3F; b_mem_data = 6'h3A;
    @(negedge clk);
    checks++;
    if ({b_mem_valid, b_mem_addr, b_gnt_id, b_busy} !== {1'b1, 6'h3F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL lat3_grant: valid=%0b addr=%h gnt=%0b busy=%0b, required 1 3f 1 1",
               b_mem_valid, b_mem_addr, b_gnt_id, b_busy);
    end
    b_mem_data = 6'h01;
    @(negedge clk);
    checks++;
    if ({b_mem_valid, b_ack1} !== 2'b10) begin
      errors++;
      $display("FAIL lat3_wait1: valid=%0b ack1=%0b, required 1 0", b_mem_valid, b_ack1);
    end
    b_mem_data = 6'h02;
    @(negedge clk);
    checks++;
    if ({b_mem_valid, b_ack1} !== 2'b10) begin
      errors++;
      $display("FAIL lat3_wait2: valid=%0b ack1=%0b, required 1 0", b_mem_valid, b_ack1);
    end
    b_mem_data = 6'h2C;
    b_req1 = 0;
    @(negedge clk);
    checks++;
    if ({b_ack1, b_ack0, b_mem_valid, b_rdata} !== {1'b1, 1'b0, 1'b0, 6'h2C}) begin
      errors++;
      $display("FAIL lat3_ack: ack1=%0b ack0=%0b valid=%0b rdata=%h, required 1 0 0 2c",
               b_ack1, b_ack0, b_mem_valid, b_rdata);
    end
    b_mem_data = 6'h15;
    @(negedge clk);
    checks++;
    if ({b_ack1, b_rdata} !== {1'b0, 6'h2C}) begin
      errors++;
      $display("FAIL lat3_hold: ack1=%0b rdata=%h, required 0 2c", b_ack1, b_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk);
    req0 = 1; addr0 = 6'h09;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy: busy=%0b, required 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_valid, busy, ack0} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_async: valid=%0b busy=%0b ack0=%0b, required 0 0 0", mem_valid, busy, ack0);
    end
    @(negedge clk);
    checks++;
    if ({ack0, ack1} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_noack: ack0=%0b ack1=%0b, required 0 0", ack0, ack1);
    end
    sb.push_back('{1'b0, memf(6'h09)});
    reset = 1'b0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      @(negedge clk);
      if (ack0) begin n = 1; req0 = 0; end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL rmid_resume: ack0 seen=%0d, required 1", n);
    end
  endtask

  task automatic test_wait_ignore();
    @(negedge clk);
    req0 = 1; addr0 = 6'h12;
    sb.push_back('{1'b0, memf(6'h12)});
    @(negedge clk);
    addr0 = 6'h33; req0 = 0;
    checks++;
    if ({mem_valid, mem_addr} !== {1'b1, 6'h12}) begin
      errors++;
      $display("FAIL wign_addr: valid=%0b addr=%h, required 1 12", mem_valid, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({ack0, mem_addr, rdata} !== {1'b1, 6'h12, memf(6'h12)}) begin
      errors++;
      $display("FAIL wign_ack: ack0=%0b addr=%h rdata=%h, required 1 12 %h", ack0, mem_addr, rdata, memf(6'h12));
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_both();
    test_held();
    test_latency3();
    test_reset_mid();
    test_wait_ignore();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d transactions pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
